request_unit: RTL and testbench
===============================

# request_unit

Sequences every instruction's memory traffic between the CPU datapath and the memory controller. It fetches the instruction at the current PC, then issues one data read or write if the decoded instruction needs it, and pulses `cpu_en` once per retired instruction so the datapath advances PC and register state. It sits directly upstream of the memory controller: it drives the `dmmRen/dmmWen/imemRen` request side and consumes `i_ready/d_ready/imemload/dmmload`.

## Interface
Parameters:
- none; all data/address paths are 32-bit `word_t`.

Ports (clock and reset first):
- `clk` in 1: sole clock; all state updates on the rising edge.
- `nRst` in 1: asynchronous, active-low reset.
- `pc` in 32: current PC from the datapath; stable until `cpu_en`.
- `dread` in 1: decoded instruction is a load.
- `dwrite` in 1: decoded instruction is a store.
- `daddr` in 32: load/store address from ALU.
- `dstore` in 32: store data.
- `halt` in 1: decoded instruction is a halt.
- `instr` out 32: latched fetched instruction.
- `dload` out 32: latched load data.
- `cpu_en` out 1: one-cycle pulse; instruction retired.
- `halted` out 1: block stopped after a halt.
- `imemRen` out 1, `imemaddr` out 32: instruction request.
- `i_ready` in 1, `imemload` in 32: instruction response.
- `dmmRen` out 1, `dmmWen` out 1, `dmmaddr` out 32, `dmmstore` out 32: data request.
- `d_ready` in 1, `dmmload` in 32: data response.

## Operation
- States: FETCH, DECIDE, DATA, DONE, HALT. Encoding is free.
- FETCH:
  - `imemRen`=1, `imemaddr`={pc[31:2],2'b00}.
  - On an edge with `i_ready`=1: `instr`<=`imemload`, go to DECIDE. Otherwise stay.
- DECIDE (datapath decodes `instr` combinationally):
  - `halt`=1: go to HALT; no `cpu_en`. `halt` has priority over memory ops.
  - else `dread` or `dwrite` =1: go to DATA.
  - else: `cpu_en`=1 this cycle, go to FETCH.
- DATA:
  - `dmmaddr`=`daddr` unmodified, `dmmstore`=`dstore`.
  - `dmmWen`=`dwrite`; `dmmRen`=`dread & ~dwrite`. Write wins if both are set; never assert both.
  - On an edge with `d_ready`=1: if read, `dload`<=`dmmload`; go to DONE. Otherwise hold the request.
- DONE: `cpu_en`=1, go to FETCH.
- HALT:
  - `halted`=1; no requests issued; `cpu_en`=0.
  - Only exit is reset.
- Request outputs are pure functions of state and inputs. Requests hold steady until ready; they are never withdrawn mid-wait.
- `instr` and `dload` hold their values until overwritten.

## Timing
- Reset (async, `nRst`=0):
  - state=FETCH.
  - `instr`=0, `dload`=0, `cpu_en`=0, `halted`=0, `dmmRen`=`dmmWen`=0.
  - `imemRen` asserts as soon as `nRst` releases, since FETCH drives it.
- Reset mid-transaction drops any outstanding request immediately. The controller must tolerate an abandoned request.
- `i_ready`/`d_ready` are sampled at the clock edge. They may be high in the same cycle the request first asserts, for zero wait states.
- Minimum cycles per instruction with zero-wait memory:
  - ALU/branch: 2 (FETCH, DECIDE).
  - Load/store: 4 (FETCH, DECIDE, DATA, DONE).
- Each wait cycle on `i_ready` or `d_ready` adds exactly one cycle.
- `cpu_en` is high for exactly one cycle per retired instruction, never in two consecutive cycles.
- `i_ready` arriving outside FETCH, or `d_ready` arriving outside DATA, is ignored.

## Test plan
- Reset with `nRst`=0 mid-DATA, `dmmWen`=1 -> all outputs immediately reach their reset values; after release, `imemRen`=1 with `imemaddr`=pc.
- ALU instruction, `pc`=0x100, `i_ready` tied 1, `imemload`=0x00A00093 -> `imemaddr`=0x100, `instr`=0x00A00093 on the next cycle, and `cpu_en` pulses in cycle 2.
- Load, `daddr`=0x2004, `d_ready` delayed 3 cycles, `dmmload`=0xDEADBEEF -> `dmmRen` held 4 cycles with `dmmaddr`=0x2004, `dload`=0xDEADBEEF, then one `cpu_en` pulse.
- Store, `dstore`=0x12345678, `daddr`=0x3000 -> `dmmWen`=1 and `dmmRen`=0, `dmmstore`=0x12345678 until `d_ready`; `dload` unchanged.
- `dread`=`dwrite`=1 -> only `dmmWen` asserts. Separately, `halt`=1 in DECIDE -> `halted`=1, with no further `imemRen` or `cpu_en` for 20 cycles.
- Unaligned `pc`=0x103 -> `imemaddr`=0x100; with `i_ready` stuck 0 the request holds and `cpu_en` stays 0.

Source files
------------

// File: rtl/request_unit.sv
// request_unit: sequences instruction fetch and the optional data access for
// each instruction, and pulses cpu_en once per retired instruction.
module request_unit (
  input  logic        clk,
  input  logic        nRst,
  // datapath side
  input  logic [31:0] pc,
  input  logic        dread,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] dload,
  output logic        cpu_en,
  output logic        halted,
  // instruction memory side
  output logic        imemRen,
  output logic [31:0] imemaddr,
  input  logic        i_ready,
  input  logic [31:0] imemload,
  // data memory side
  output logic        dmmRen,
  output logic        dmmWen,
  output logic [31:0] dmmaddr,
  output logic [31:0] dmmstore,
  input  logic        d_ready,
  input  logic [31:0] dmmload
);

  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECIDE,
    S_DATA,
    S_DONE,
    S_HALT
  } state_t;

  state_t state_q, state_d;
  word_t  instr_q, instr_d;
  word_t  dload_q, dload_d;

  // The byte offset of pc is dropped; instruction fetches are word aligned.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^pc[1:0];

  // Read is suppressed when a write is also requested; write wins.
  logic is_read;
  assign is_read = dread & ~dwrite;

  // Next-state and latch-update logic.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    dload_d = dload_q;
    unique case (state_q)
      S_FETCH: begin
        if (i_ready) begin
          instr_d = imemload;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (dread || dwrite) begin
          state_d = S_DATA;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DATA: begin
        if (d_ready) begin
          if (is_read) begin
            dload_d = dmmload;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and latched-data registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_FETCH;
      instr_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      dload_q <= dload_d;
    end
  end

  // Request and status outputs decoded from state; requests drop while in reset.
  always_comb begin
    imemRen  = 1'b0;
    dmmRen   = 1'b0;
    dmmWen   = 1'b0;
    cpu_en   = 1'b0;
    halted   = 1'b0;
    imemaddr = {pc[WORD_W-1:2], 2'b00};
    dmmaddr  = daddr;
    dmmstore = dstore;
    unique case (state_q)
      S_FETCH: begin
        imemRen = nRst;
      end
      S_DECIDE: begin
        cpu_en = ~halt & ~dread & ~dwrite;
      end
      S_DATA: begin
        dmmWen = dwrite;
        dmmRen = is_read;
      end
      S_DONE: begin
        cpu_en = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        imemRen = 1'b0;
      end
    endcase
  end

  assign instr = instr_q;
  assign dload = dload_q;

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: a small memory model answers the
// requests with programmable wait states; retirements are scored against
// expectations queued when each instruction is driven.
module tb_request_unit;

  logic        clk;
  logic        nRst;
  logic [31:0] pc;
  logic        dread;
  logic        dwrite;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] dload;
  logic        cpu_en;
  logic        halted;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        i_ready;
  logic [31:0] imemload;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic        d_ready;
  logic [31:0] dmmload;

  int          n_cmp;
  int          n_fail;
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_dload_q[$];
  logic [31:0] last_dload;

  request_unit dut (
    .clk      (clk),
    .nRst     (nRst),
    .pc       (pc),
    .dread    (dread),
    .dwrite   (dwrite),
    .daddr    (daddr),
    .dstore   (dstore),
    .halt     (halt),
    .instr    (instr),
    .dload    (dload),
    .cpu_en   (cpu_en),
    .halted   (halted),
    .imemRen  (imemRen),
    .imemaddr (imemaddr),
    .i_ready  (i_ready),
    .imemload (imemload),
    .dmmRen   (dmmRen),
    .dmmWen   (dmmWen),
    .dmmaddr  (dmmaddr),
    .dmmstore (dmmstore),
    .d_ready  (d_ready),
    .dmmload  (dmmload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction to retirement, answering requests with the given waits.
  task automatic run_instr(input logic [31:0] a_pc, input logic [31:0] a_word,
                           input logic a_rd, input logic a_wr,
                           input logic [31:0] a_addr, input logic [31:0] a_store,
                           input logic [31:0] a_load, input int a_iw, input int a_dw);
    int          cyc;
    int          icnt;
    int          dcnt;
    int          exp_cyc;
    bit          mem;
    bit          done;
    logic [31:0] e_instr;
    logic [31:0] e_dload;
    pc = a_pc; imemload = a_word; dread = a_rd; dwrite = a_wr;
    daddr = a_addr; dstore = a_store; dmmload = a_load; halt = 1'b0;
    i_ready = 1'b0; d_ready = 1'b0;
    mem = a_rd | a_wr;
    exp_instr_q.push_back(a_word);
    if (a_rd && !a_wr) last_dload = a_load;
    exp_dload_q.push_back(last_dload);
    exp_cyc = 2 + a_iw + (mem ? 2 + a_dw : 0);
    #1;
    cyc = 0; icnt = 0; dcnt = 0; done = 0;
    while (!done && cyc < 60) begin
      cyc++;
      i_ready = 1'b0;
      d_ready = 1'b0;
      if (imemRen) begin
        n_cmp++;
        if (imemaddr !== {a_pc[31:2], 2'b00}) begin
          n_fail++;
          $display("FAIL imemaddr: got %h want %h", imemaddr, {a_pc[31:2], 2'b00});
        end
        i_ready = (icnt == a_iw);
        icnt++;
      end
      if (dmmRen || dmmWen) begin
        n_cmp++;
        if (dmmaddr !== a_addr || dmmstore !== a_store || dmmWen !== a_wr ||
            dmmRen !== (a_rd && !a_wr)) begin
          n_fail++;
          $display("FAIL data_req: got addr=%h st=%h wen=%b ren=%b want addr=%h st=%h wen=%b ren=%b",
                   dmmaddr, dmmstore, dmmWen, dmmRen, a_addr, a_store, a_wr, a_rd && !a_wr);
        end
        d_ready = (dcnt == a_dw);
        dcnt++;
      end
      if (cpu_en) begin
        done = 1;
        if (exp_instr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL retire_unexpected: got cpu_en=1 want no retirement");
        end else begin
          e_instr = exp_instr_q.pop_front();
          e_dload = exp_dload_q.pop_front();
          n_cmp++;
          if (instr !== e_instr) begin
            n_fail++;
            $display("FAIL instr: got %h want %h", instr, e_instr);
          end
          n_cmp++;
          if (dload !== e_dload) begin
            n_fail++;
            $display("FAIL dload: got %h want %h", dload, e_dload);
          end
          n_cmp++;
          if (cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want %0d", cyc, exp_cyc);
          end
        end
      end
      @(posedge clk); #1;
    end
    i_ready = 1'b0;
    d_ready = 1'b0;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: got no cpu_en after %0d cycles want %0d", cyc, exp_cyc);
    end
    n_cmp++;
    if (icnt !== a_iw + 1 || dcnt !== (mem ? a_dw + 1 : 0)) begin
      n_fail++;
      $display("FAIL req_cycles: got i=%0d d=%0d want i=%0d d=%0d",
               icnt, dcnt, a_iw + 1, mem ? a_dw + 1 : 0);
    end
    n_cmp++;
    if (cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_en_repeat: got %b want 0 after retirement", cpu_en);
    end
  endtask

  // Apply and release reset between instructions.
  task automatic do_reset();
    pc = '0; dread = 0; dwrite = 0; daddr = '0; dstore = '0; halt = 0;
    i_ready = 0; d_ready = 0; imemload = '0; dmmload = '0;
    nRst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nRst = 1'b1;
    last_dload = '0;
    exp_instr_q.delete();
    exp_dload_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    nRst = 1'b0;
    #1;
    n_cmp++;
    if (instr !== 32'h0 || dload !== 32'h0 || cpu_en !== 1'b0 || halted !== 1'b0 ||
        dmmRen !== 1'b0 || dmmWen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got instr=%h dload=%h cpu_en=%b halted=%b ren=%b wen=%b want all 0",
               instr, dload, cpu_en, halted, dmmRen, dmmWen);
    end
    @(posedge clk); #1;
    nRst = 1'b1;
    pc = 32'h0000_0040;
    #1;
    n_cmp++;
    if (imemRen !== 1'b1 || imemaddr !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL reset_release: got imemRen=%b addr=%h want 1 00000040", imemRen, imemaddr);
    end
    pc = '0;
  endtask

  task automatic test_alu();
    run_instr(32'h100, 32'h00A0_0093, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    run_instr(32'h104, 32'h0010_0113, 0, 0, 32'h0, 32'h0, 32'h0, 2, 0);
  endtask

  task automatic test_load();
    run_instr(32'h108, 32'h0041_2183, 1, 0, 32'h2004, 32'h0, 32'hDEAD_BEEF, 0, 3);
  endtask

  task automatic test_store();
    run_instr(32'h10C, 32'h0031_2023, 0, 1, 32'h3000, 32'h1234_5678, 32'hCAFE_F00D, 1, 2);
  endtask

  task automatic test_read_write_both();
    run_instr(32'h110, 32'h0052_2223, 1, 1, 32'h3004, 32'hA5A5_5A5A, 32'h0BAD_0BAD, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < 8; i++) begin
      kind = int'($urandom_range(0, 2));
      a = $urandom & 32'hFFFF_FFFC;
      run_instr($urandom, $urandom, kind == 1, kind == 2, a, $urandom, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid_data();
    int cyc;
    pc = 32'h200; imemload = 32'h0011_2023; dwrite = 1; dread = 0; halt = 0;
    daddr = 32'h4000; dstore = 32'h0000_0055; i_ready = 1; d_ready = 0;
    cyc = 0;
    #1;
    while (dmmWen !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    i_ready = 0;
    n_cmp++;
    if (dmmWen !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_data: got dmmWen=%b want 1 within 10 cycles", dmmWen);
    end
    nRst = 1'b0;
    #1;
    n_cmp++;
    if (instr !== 32'h0 || dload !== 32'h0 || cpu_en !== 1'b0 || halted !== 1'b0 ||
        dmmRen !== 1'b0 || dmmWen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_data: got instr=%h dload=%h cpu_en=%b halted=%b ren=%b wen=%b want all 0",
               instr, dload, cpu_en, halted, dmmRen, dmmWen);
    end
    last_dload = '0;
    exp_instr_q.delete();
    exp_dload_q.delete();
    @(posedge clk); #1;
    nRst = 1'b1;
    #1;
    n_cmp++;
    if (imemRen !== 1'b1 || imemaddr !== 32'h200) begin
      n_fail++;
      $display("FAIL mid_data_release: got imemRen=%b addr=%h want 1 00000200", imemRen, imemaddr);
    end
    dwrite = 0;
  endtask

  task automatic test_unaligned_stall();
    int bad;
    pc = 32'h103; i_ready = 0;
    bad = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (imemRen !== 1'b1 || imemaddr !== 32'h100 || cpu_en !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL unaligned_stall: got %0d bad cycles (ren=%b addr=%h cpu_en=%b) want 0",
               bad, imemRen, imemaddr, cpu_en);
    end
  endtask

  task automatic test_halt();
    int bad;
    do_reset();
    pc = 32'h300; imemload = 32'h0000_0073; halt = 1; dread = 1; dwrite = 0;
    i_ready = 1; d_ready = 1;
    #1;
    n_cmp++;
    if (imemRen !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_fetch: got imemRen=%b want 1", imemRen);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cpu_en !== 1'b0 || instr !== 32'h0000_0073) begin
      n_fail++;
      $display("FAIL halt_decide: got cpu_en=%b instr=%h want 0 00000073", cpu_en, instr);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (halted !== 1'b1 || imemRen !== 1'b0 || cpu_en !== 1'b0 ||
          dmmRen !== 1'b0 || dmmWen !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halted_hold: got %0d bad cycles (halted=%b ren=%b cpu_en=%b dren=%b) want 0",
               bad, halted, imemRen, cpu_en, dmmRen);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    last_dload = '0;
    nRst = 1'b0;
    pc = '0; dread = 0; dwrite = 0; daddr = '0; dstore = '0; halt = 0;
    i_ready = 0; d_ready = 0; imemload = '0; dmmload = '0;
    test_reset();
    do_reset();
    test_alu();
    test_load();
    test_store();
    test_read_write_both();
    test_back_to_back();
    test_load();
    test_reset_mid_data();
    test_unaligned_stall();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
